// File: rtl/div_iter_pkg.sv
// Shared names for the iterative divider and the EX stage that drives it.
// State encodings, handshake levels and the legacy zero word live here so
// both sides of the interface agree on them.
package div_iter_pkg;

    // Divider control states; DivFree is the idle state.
    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    // Request levels on start_i.
    localparam logic DivStart = 1'b1;
    localparam logic DivStop  = 1'b0;

    // Levels on ready_o.
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    // Legacy 32-bit zero constant still used by the EX stage.
    localparam logic [31:0] ZeroWord = 32'h0000_0000;

endpackage

// File: rtl/div_lzc.sv
// Parametrised leading-zero counter. Returns DATA_W for an all-zero input.
// Only instantiated by div_iter when DIV_EARLY_OUT_EN is defined.
module div_lzc #(
    parameter int unsigned DATA_W = 32,
    localparam int unsigned CNT_W = $clog2(DATA_W) + 1
) (
    input  logic [DATA_W-1:0] data_i,
    output logic [CNT_W-1:0]  cnt_o
);

    // Scan upward so the highest set bit writes last and wins.
    always_comb begin
        cnt_o = CNT_W'(DATA_W);
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (data_i[i]) begin
                cnt_o = CNT_W'(DATA_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle.
// result_o = {remainder, quotient}; signed mode truncates toward zero and the
// remainder takes the dividend's sign. DATA_W must be even and >= 4.
// Optional feature: define DIV_EARLY_OUT_EN to skip the dividend's leading
// zeros at acceptance (results are identical, latency shrinks).
module div_iter
    import div_iter_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                annul_i,
    input  logic                signed_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o,
    output logic                busy_o,
    output logic                div_zero_o
);

    localparam int unsigned CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DATA_W - 1);

    div_state_e state_q, state_d;

    logic [DATA_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]   quo_q, quo_d;
    logic [DATA_W-1:0]   dvs_q, dvs_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                neg_quo_q, neg_quo_d;
    logic                neg_rem_q, neg_rem_d;
    logic [2*DATA_W-1:0] result_q, result_d;
    logic                div_zero_q, div_zero_d;

    logic [DATA_W-1:0] abs_dvd, abs_dvs;
    logic [DATA_W-1:0] dvd_init;
    logic [CNT_W-1:0]  cnt_init;

    logic [DATA_W:0]   rem_shift, trial;
    logic [DATA_W-1:0] step_rem, step_quo;
    logic [DATA_W-1:0] fin_rem, fin_quo;

    // Operand magnitudes; two's-complement negate only for signed negative inputs.
    always_comb begin
        abs_dvd = (signed_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
        abs_dvs = (signed_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
    end

`ifdef DIV_EARLY_OUT_EN
    logic [CNT_W-1:0] lz_raw, lz_eff;

    div_lzc #(
        .DATA_W (DATA_W)
    ) u_lzc (
        .data_i (abs_dvd),
        .cnt_o  (lz_raw)
    );

    // Cap the skip so a zero dividend still runs one step.
    assign lz_eff   = (lz_raw == CNT_W'(DATA_W)) ? LastCnt : lz_raw;
    assign dvd_init = abs_dvd << lz_eff;
    assign cnt_init = lz_eff;
`else
    assign dvd_init = abs_dvd;
    assign cnt_init = '0;
`endif

    // One restoring step: shift {rem,quo} left, keep the difference if no borrow.
    always_comb begin
        rem_shift = {rem_q, quo_q[DATA_W-1]};
        trial     = rem_shift - {1'b0, dvs_q};
        step_rem  = trial[DATA_W] ? rem_shift[DATA_W-1:0] : trial[DATA_W-1:0];
        step_quo  = {quo_q[DATA_W-2:0], ~trial[DATA_W]};
        fin_quo   = neg_quo_q ? -step_quo : step_quo;
        fin_rem   = neg_rem_q ? -step_rem : step_rem;
    end

    // Next-state and datapath control.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        cnt_d      = cnt_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        div_zero_d = div_zero_q;

        unique case (state_q)
            DivFree: begin
                if (start_i == DivStart && !annul_i) begin
                    div_zero_d = 1'b0;
                    if (opdata2_i == '0) begin
                        state_d = DivByZero;
                    end else begin
                        state_d   = DivOn;
                        rem_d     = '0;
                        quo_d     = dvd_init;
                        dvs_d     = abs_dvs;
                        cnt_d     = cnt_init;
                        neg_quo_d = signed_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                        neg_rem_d = signed_i & opdata1_i[DATA_W-1];
                    end
                end
            end
            DivByZero: begin
                result_d = '0;
                if (annul_i) begin
                    state_d    = DivFree;
                    div_zero_d = 1'b0;
                end else begin
                    state_d    = DivEnd;
                    div_zero_d = 1'b1;
                end
            end
            DivOn: begin
                if (annul_i) begin
                    state_d    = DivFree;
                    result_d   = '0;
                    div_zero_d = 1'b0;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LastCnt) begin
                        state_d  = DivEnd;
                        result_d = {fin_rem, fin_quo};
                    end
                end
            end
            DivEnd: begin
                if (annul_i) begin
                    state_d    = DivFree;
                    result_d   = '0;
                    div_zero_d = 1'b0;
                end else if (start_i == DivStop) begin
                    state_d = DivFree;
                end
            end
            default: state_d = DivFree;
        endcase
    end

    // State and datapath registers, asynchronously cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= DivFree;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            cnt_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            cnt_q      <= cnt_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            div_zero_q <= div_zero_d;
        end
    end

    // Outputs decoded straight from registered state.
    always_comb begin
        ready_o    = (state_q == DivEnd) ? DivResultReady : DivResultNotReady;
        busy_o     = (state_q == DivOn) || (state_q == DivByZero);
        result_o   = result_q;
        div_zero_o = div_zero_q;
    end

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter (DATA_W=32): the driver pushes reference
// results, a monitor pops and compares on each rising ready_o.
module tb_div_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic        signed_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;
    logic        div_zero_o;

    div_iter #(
        .DATA_W (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .annul_i    (annul_i),
        .signed_i   (signed_i),
        .opdata1_i  (opdata1_i),
        .opdata2_i  (opdata2_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .busy_o     (busy_o),
        .div_zero_o (div_zero_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] res;
        logic        dz;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int exp_lat(input bit s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] mag;
        int lz;
        if (b == 0) return 2;
        mag = (s && a[31]) ? (32'd0 - a) : a;
        lz = 0;
`ifdef DIV_EARLY_OUT_EN
        while (lz < 31 && mag[31-lz] == 1'b0) lz++;
`endif
        return 32 - lz + 1;
    endfunction

    function automatic exp_t model(input bit s, input logic [31:0] a, input logic [31:0] b);
        exp_t r;
        int sa, sd;
        logic [31:0] q, m;
        r.acc = 0;
        if (b == 0) begin
            r.res = '0;
            r.dz  = 1'b1;
        end else begin
            r.dz = 1'b0;
            if (s) begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    q = 32'h8000_0000;
                    m = '0;
                end else begin
                    sa = a;
                    sd = b;
                    q  = sa / sd;
                    m  = sa % sd;
                end
            end else begin
                q = a / b;
                m = a % b;
            end
            r.res = {m, q};
        end
        r.lat = exp_lat(s, a, b);
        return r;
    endfunction

    // Monitor: one scoreboard entry per rising ready_o.
    exp_t mon_e;
    logic ready_prev = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            ready_prev = 1'b0;
        end else begin
            if (ready_o && !ready_prev) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ready: got ready_o=1 expected no result (cycle %0d)",
                             cyc);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("result", result_o, mon_e.res);
                    chk("div_zero", 64'(div_zero_o), 64'(mon_e.dz));
                    chk("latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
                end
            end
            ready_prev = ready_o;
        end
    end

    // Issue one request, hold start_i through ready plus `hold` extra cycles.
    task automatic do_op(input bit s, input logic [31:0] a, input logic [31:0] b,
                         input int hold);
        exp_t e;
        int n;
        while (ready_o || busy_o) @(negedge clk);
        signed_i  = s;
        opdata1_i = a;
        opdata2_i = b;
        start_i   = 1'b1;
        e = model(s, a, b);
        e.acc = cyc;
        sbq.push_back(e);
        n = 0;
        while (!ready_o && n < 200) begin
            @(negedge clk);
            n++;
            if (n == 3) begin
                // Operands are latched at acceptance; disturb them mid-run.
                opdata1_i = $urandom;
                opdata2_i = $urandom;
                signed_i  = ~signed_i;
            end
        end
        if (!ready_o) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got no ready_o expected within 200 cycles");
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_ready", 64'(ready_o), 64'd1);
            chk("hold_result", result_o, e.res);
            chk("hold_div_zero", 64'(div_zero_o), 64'(e.dz));
        end
        start_i = 1'b0;
        @(negedge clk);
        chk("drop_ready", 64'(ready_o), 64'd0);
    endtask

    bit          s;
    logic [31:0] a, b;

    initial begin
        #1 rst = 1'b1;
        #2;
        chk("rst_result", result_o, 64'd0);
        chk("rst_ready", 64'(ready_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_div_zero", 64'(div_zero_o), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_op(1'b1, 32'd100, 32'd7, 0);
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        do_op(1'b0, 32'hFFFF_FFF9, 32'd2, 0);
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op(1'b0, 32'h1234_5678, 32'd0, 5);
        do_op(1'b0, 32'd5, 32'd1, 0);
        do_op(1'b1, 32'd100, 32'd7, 0);

        // start_i with annul_i in idle is ignored.
        start_i   = 1'b1;
        annul_i   = 1'b1;
        opdata2_i = 32'd5;
        @(negedge clk);
        chk("annul_idle_busy", 64'(busy_o), 64'd0);
        chk("annul_idle_ready", 64'(ready_o), 64'd0);
        start_i = 1'b0;
        annul_i = 1'b0;
        @(negedge clk);

        // Annul ten cycles into an operation, then restart at once.
        signed_i  = 1'b0;
        opdata1_i = 32'hDEAD_BEEF;
        opdata2_i = 32'd3;
        start_i   = 1'b1;
        repeat (10) @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        chk("annul_busy", 64'(busy_o), 64'd0);
        chk("annul_ready", 64'(ready_o), 64'd0);
        chk("annul_result", result_o, 64'd0);
        chk("annul_div_zero", 64'(div_zero_o), 64'd0);
        annul_i = 1'b0;
        do_op(1'b0, 32'd9, 32'd3, 0);

        // Asynchronous reset between clock edges while ON.
        signed_i  = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        repeat (5) @(negedge clk);
        chk("pre_rst_busy", 64'(busy_o), 64'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        start_i = 1'b0;
        #1;
        chk("arst_result", result_o, 64'd0);
        chk("arst_ready", 64'(ready_o), 64'd0);
        chk("arst_busy", 64'(busy_o), 64'd0);
        chk("arst_div_zero", 64'(div_zero_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 50; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = '0;
                1: b = 32'($urandom_range(1, 15));
                2: begin
                    a = a >> $urandom_range(0, 31);
                    b = $urandom;
                end
                3: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: b = $urandom;
            endcase
            do_op(s, a, b, $urandom_range(0, 2));
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
